serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  augend; captured on the accepting edge.
REQ-006 b  input  WIDTH  addend; captured on the accepting edge.
REQ-007 cin  input  1  carry-in; captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the addition.

Function
REQ-012 The block SHALL add one bit per cycle, LSB first, using a full-adder equation on the shift-register LSBs and a carry register: s = a_i^b_i^c, c' = a_i&b_i | c&(a_i^b_i).
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE transitions: start=1 -> RUN; start=0 -> stay in IDLE.
REQ-015 RUN transitions: stay in RUN until WIDTH bits are processed, then go to DONE.
REQ-016 DONE transitions: always go to IDLE on the next edge.
REQ-017 On the accepting edge E0 (IDLE, start=1) the block SHALL load a, b into internal shift registers, load cin into the carry register, clear the bit counter and enter RUN.
REQ-018 Each RUN edge SHALL shift the computed bit into the MSB of an internal result register, shift the operand registers right by one, update the carry and increment the counter.
REQ-019 On RUN edge E_WIDTH (the WIDTH-th RUN edge) the block SHALL load sum with the completed result, load cout with the final carry, set done=1 and enter DONE.
REQ-020 Latency SHALL be WIDTH cycles from E0 to done high; done SHALL be high for exactly one cycle.
REQ-021 busy SHALL be high from E0 until E_WIDTH, and low in IDLE and DONE.
REQ-022 sum and cout SHALL change only at E_WIDTH and hold their values until the next completion or reset.
REQ-023 start while busy or in DONE SHALL be ignored; no operands are captured and the current operation is unaffected.
REQ-024 Back-to-back operation: start=1 held continuously SHALL begin a new operation on the first edge back in IDLE, giving one done every WIDTH+2 cycles.
REQ-025 Changes on a, b or cin after E0 SHALL NOT affect the in-flight result.
REQ-026 Counter width SHALL be clog2(WIDTH)+1 bits; the counter SHALL NOT wrap within an operation.

Reset
REQ-027 While rst=1 the block SHALL immediately, without waiting for a clock edge, force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear the internal shift registers, carry register and counter.
REQ-028 Assertion of rst mid-operation SHALL abort the operation with no done pulse and no update of sum or cout beyond the reset values.
REQ-029 The first start SHALL be accepted on the first rising edge at which rst=0 and start=1.

Verification (WIDTH=8)
REQ-030 Start with a=8'h00, b=8'h00, cin=0 -> after 8 cycles done pulses once; sum=8'h00, cout=0.
REQ-031 Start with a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; busy high for exactly 8 cycles.
REQ-032 Start with a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; also a=8'h64, b=8'h37, cin=0 -> sum=8'h9B, cout=0.
REQ-033 Pulse start with new operands at RUN cycle 3 -> ignored; the original result is produced and no extra done pulse occurs.
REQ-034 Assert rst at RUN cycle 4 (between clock edges) -> busy=0, sum=0, cout=0 immediately, and no done pulse; a subsequent start completes normally.
REQ-035 Hold start=1 for three operations -> done pulses exactly 10 cycles apart, each with the correct sum for the operands present at its accepting edge.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one sum bit per clock, LSB first
// IDLE -> RUN (WIDTH cycles) -> DONE (one-cycle done pulse) -> IDLE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] res_next;

  // Full adder on the operand LSBs; the new bit enters the result MSB so
  // that after WIDTH shifts the first (LSB) bit has reached bit 0.
  always_comb begin
    s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    c_next   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    res_next = {s_bit, res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            res_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_sr <= res_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c_next;
          cnt    <= cnt + CW'(1);
          // Results are published on the WIDTH-th RUN edge only.
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= c_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int passed = 0;
  int total  = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Issues one start at the next posedge, then samples W+4 negedges.
  // lat counts edges from the accepting edge to the one that raised done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, output logic [W-1:0] s, output logic c,
                        output int lat, output int ndone, output int nbusy);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    lat = -1; ndone = 0; nbusy = 0; s = '0; c = 1'b0;
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i - 1;
          s = sum;
          c = cout;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, sum, cout} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0",
               busy, done, sum, cout);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [6] = '{8'h00, 8'hFF, 8'hA5, 8'h64, 8'h12, 8'hFF};
    logic [W-1:0] vb [6] = '{8'h00, 8'h01, 8'h5A, 8'h37, 8'h34, 8'hFF};
    logic         vc [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    logic [W-1:0] es [6] = '{8'h00, 8'h00, 8'h00, 8'h9B, 8'h47, 8'hFF};
    logic         ec [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    logic [W-1:0] s;
    logic         c;
    int           lat, nd, nb;
    for (int k = 0; k < 6; k++) begin
      run_op(va[k], vb[k], vc[k], s, c, lat, nd, nb);
      total++;
      if (s !== es[k] || c !== ec[k])
        $display("FAIL add_%0d: got sum=%h cout=%b, want sum=%h cout=%b", k, s, c, es[k], ec[k]);
      else passed++;
      total++;
      if (lat != W || nd != 1)
        $display("FAIL timing_%0d: got latency=%0d pulses=%0d, want latency=%0d pulses=1", k, lat, nd, W);
      else passed++;
      total++;
      if (nb != W)
        $display("FAIL busy_len_%0d: got %0d cycles, want %0d", k, nb, W);
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int nd = 0;
    logic [W-1:0] s = '0;
    logic c = 1'b0;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= W + 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end
      if (i == 5) begin
        a = 8'h77; b = 8'h01;
      end
      if (done) begin
        nd++;
        s = sum;
        c = cout;
      end
    end
    total++;
    if (s !== 8'h30 || c !== 1'b0 || nd != 1)
      $display("FAIL ignore_start: got sum=%h cout=%b pulses=%0d, want sum=30 cout=0 pulses=1", s, c, nd);
    else passed++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL ignore_no_restart: got busy=%b, want 0", busy);
    else passed++;
  endtask

  task automatic test_rst_mid();
    int nd = 0;
    logic [W-1:0] s;
    logic c;
    int lat, nb;
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0)
      $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    total++;
    if (nd != 0 || sum !== '0)
      $display("FAIL reset_abort: got pulses=%0d sum=%h, want pulses=0 sum=00", nd, sum);
    else passed++;
    run_op(8'h0F, 8'h01, 1'b0, s, c, lat, nd, nb);
    total++;
    if (s !== 8'h10 || c !== 1'b0 || lat != W || nd != 1)
      $display("FAIL after_reset: got sum=%h cout=%b lat=%0d pulses=%0d, want sum=10 cout=0 lat=%0d pulses=1",
               s, c, lat, nd, W);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa [3] = '{8'h01, 8'hF0, 8'h55};
    logic [W-1:0] ob [3] = '{8'h02, 8'h0F, 8'h33};
    logic         oc [3] = '{1'b0,  1'b1,  1'b0};
    logic [W-1:0] es [3] = '{8'h03, 8'h00, 8'h88};
    logic         ec [3] = '{1'b0,  1'b1,  1'b0};
    int stamp [3];
    int nd = 0;
    a = oa[0]; b = ob[0]; cin = oc[0]; start = 1'b1;
    for (int i = 1; i <= 50 && nd < 3; i++) begin
      @(negedge clk);
      if (done) begin
        stamp[nd] = i;
        total++;
        if (sum !== es[nd] || cout !== ec[nd])
          $display("FAIL b2b_sum_%0d: got sum=%h cout=%b, want sum=%h cout=%b", nd, sum, cout, es[nd], ec[nd]);
        else passed++;
        nd++;
        if (nd < 3) begin
          a = oa[nd]; b = ob[nd]; cin = oc[nd];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    total++;
    if (nd != 3)
      $display("FAIL b2b_count: got %0d pulses, want 3", nd);
    else begin
      passed++;
      total++;
      if (stamp[1] - stamp[0] != W + 2 || stamp[2] - stamp[1] != W + 2)
        $display("FAIL b2b_spacing: got %0d and %0d, want %0d", stamp[1] - stamp[0],
                 stamp[2] - stamp[1], W + 2);
      else passed++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy, done);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
